// File: rtl/vrf_rename_unit.sv
// Vector register renamer: maps architectural vd/vs1/vs2 groups to physical
// VRF base addresses, allocating fresh registers for vd from a circular free list.
module vrf_rename_unit #(
    parameter int unsigned VLEN      = 4096,
    parameter int unsigned VLANE_NUM = 8,
    parameter int unsigned PHYS_REGS = 48,
    localparam int unsigned REG_SIZE = VLEN / 32 / VLANE_NUM,
    localparam int unsigned PREG_W   = $clog2(PHYS_REGS),
    localparam int unsigned ADDR_W   = $clog2(PHYS_REGS * REG_SIZE)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  instr_vld_i,
    output logic                  instr_rdy_o,
    input  logic [31:0]           vector_instr_i,
    input  logic [1:0]            lmul_i,
    input  logic                  we_i,
    output logic                  vrf_starting_addr_vld_o,
    input  logic                  vrf_starting_addr_rdy_i,
    output logic [8*ADDR_W-1:0]   vrf_starting_waddr_o,
    output logic [8*ADDR_W-1:0]   vrf_starting_raddr0_o,
    output logic [8*ADDR_W-1:0]   vrf_starting_raddr1_o,
    output logic [8*PREG_W-1:0]   old_preg_o,
    input  logic                  rel_vld_i,
    input  logic [PREG_W-1:0]     rel_preg_i,
    output logic [PREG_W:0]       free_cnt_o,
    output logic                  ovf_err_o
);

    localparam int unsigned FL_DEPTH = PHYS_REGS - 32;
    localparam int unsigned PTR_W    = (FL_DEPTH > 1) ? $clog2(FL_DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ALLOC = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t              state;
    logic [PREG_W-1:0]   rtab    [32];
    logic [PREG_W-1:0]   fl_mem  [FL_DEPTH];
    logic [PTR_W-1:0]    rd_ptr;
    logic [PTR_W-1:0]    wr_ptr;
    logic [PREG_W:0]     fl_cnt;
    logic                ovf;
    logic                vld_q;
    logic [4:0]          vd_q;
    logic [3:0]          nreg_q;
    logic [2:0]          k_q;
    logic [ADDR_W-1:0]   waddr_q  [8];
    logic [ADDR_W-1:0]   raddr0_q [8];
    logic [ADDR_W-1:0]   raddr1_q [8];
    logic [PREG_W-1:0]   old_q    [8];

    logic [4:0]          vd;
    logic [4:0]          vs1;
    logic [4:0]          vs2;
    logic [3:0]          nreg_in;
    logic                fl_full;
    logic                fl_empty;
    logic                pop;
    logic                push;
    logic [PREG_W-1:0]   pop_preg;
    logic [4:0]          alloc_idx;
    logic                last_pop;
    logic                unused_instr_bits;

    assign vd       = vector_instr_i[11:7];
    assign vs1      = vector_instr_i[19:15];
    assign vs2      = vector_instr_i[24:20];
    assign nreg_in  = 4'd1 << lmul_i;
    assign unused_instr_bits = ^{vector_instr_i[31:25], vector_instr_i[14:12], vector_instr_i[6:0]};

    assign fl_full   = (fl_cnt == (PREG_W+1)'(FL_DEPTH));
    assign fl_empty  = (fl_cnt == '0);
    assign pop       = (state == ALLOC) && !fl_empty;
    // A release into a full list still fits when a pop frees a slot the same cycle.
    assign push      = rel_vld_i && (!fl_full || pop);
    assign pop_preg  = fl_mem[rd_ptr];
    assign alloc_idx = vd_q + 5'(k_q);
    assign last_pop  = ({1'b0, k_q} == (nreg_q - 4'd1));

    function automatic logic [ADDR_W-1:0] base_addr(input logic [PREG_W-1:0] p);
        return ADDR_W'(32'(p) * REG_SIZE);
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FL_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            vld_q  <= 1'b0;
            ovf    <= 1'b0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            fl_cnt <= (PREG_W+1)'(FL_DEPTH);
            vd_q   <= '0;
            nreg_q <= '0;
            k_q    <= '0;
            for (int unsigned i = 0; i < 32; i++) rtab[i] <= PREG_W'(i);
            for (int unsigned i = 0; i < FL_DEPTH; i++) fl_mem[i] <= PREG_W'(32 + i);
            for (int unsigned i = 0; i < 8; i++) begin
                waddr_q[i]  <= '0;
                raddr0_q[i] <= '0;
                raddr1_q[i] <= '0;
                old_q[i]    <= '0;
            end
        end else begin
            if (push) begin
                fl_mem[wr_ptr] <= rel_preg_i;
                wr_ptr         <= ptr_inc(wr_ptr);
            end
            if (pop) rd_ptr <= ptr_inc(rd_ptr);
            if (push && !pop)      fl_cnt <= fl_cnt + 1'b1;
            else if (pop && !push) fl_cnt <= fl_cnt - 1'b1;
            if (rel_vld_i && !push) ovf <= 1'b1;

            case (state)
                IDLE: begin
                    if (instr_vld_i) begin
                        vd_q   <= vd;
                        nreg_q <= nreg_in;
                        k_q    <= '0;
                        // Sources and old mappings are snapshotted before any vd write.
                        for (int unsigned i = 0; i < 8; i++) begin
                            waddr_q[i]  <= '0;
                            raddr0_q[i] <= base_addr(rtab[vs1 + 5'(i)]);
                            raddr1_q[i] <= base_addr(rtab[vs2 + 5'(i)]);
                            old_q[i]    <= (we_i && (4'(i) < nreg_in)) ? rtab[vd + 5'(i)] : '0;
                        end
                        if (we_i) begin
                            state <= ALLOC;
                        end else begin
                            state <= RESP;
                            vld_q <= 1'b1;
                        end
                    end
                end
                ALLOC: begin
                    if (pop) begin
                        rtab[alloc_idx] <= pop_preg;
                        waddr_q[k_q]    <= base_addr(pop_preg);
                        k_q             <= k_q + 1'b1;
                        if (last_pop) begin
                            state <= RESP;
                            vld_q <= 1'b1;
                        end
                    end
                end
                RESP: begin
                    if (vrf_starting_addr_rdy_i) begin
                        state <= IDLE;
                        vld_q <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        vrf_starting_waddr_o  = '0;
        vrf_starting_raddr0_o = '0;
        vrf_starting_raddr1_o = '0;
        old_preg_o            = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            vrf_starting_waddr_o[i*ADDR_W +: ADDR_W]  = waddr_q[i];
            vrf_starting_raddr0_o[i*ADDR_W +: ADDR_W] = raddr0_q[i];
            vrf_starting_raddr1_o[i*ADDR_W +: ADDR_W] = raddr1_q[i];
            old_preg_o[i*PREG_W +: PREG_W]            = old_q[i];
        end
    end

    assign instr_rdy_o             = (state == IDLE);
    assign vrf_starting_addr_vld_o = vld_q;
    assign free_cnt_o              = fl_cnt;
    assign ovf_err_o               = ovf;

endmodule

// File: tb/tb_vrf_rename_unit.sv
// Directed bench for vrf_rename_unit at default parameters (REG_SIZE=16, 48 pregs).
module tb_vrf_rename_unit;

    localparam int AW = 10;
    localparam int PW = 6;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            instr_vld = 1'b0;
    logic            instr_rdy;
    logic [31:0]     instr = '0;
    logic [1:0]      lmul = '0;
    logic            we = 1'b0;
    logic            res_vld;
    logic            res_rdy = 1'b0;
    logic [8*AW-1:0] waddr;
    logic [8*AW-1:0] raddr0;
    logic [8*AW-1:0] raddr1;
    logic [8*PW-1:0] old_preg;
    logic            rel_vld = 1'b0;
    logic [PW-1:0]   rel_preg = '0;
    logic [PW:0]     free_cnt;
    logic            ovf_err;

    int n_checks = 0;
    int n_errors = 0;
    int lat;
    logic got;

    always #5 clk = ~clk;

    vrf_rename_unit #(.VLEN(4096), .VLANE_NUM(8), .PHYS_REGS(48)) dut (
        .clk                     (clk),
        .rst                     (rst),
        .instr_vld_i             (instr_vld),
        .instr_rdy_o             (instr_rdy),
        .vector_instr_i          (instr),
        .lmul_i                  (lmul),
        .we_i                    (we),
        .vrf_starting_addr_vld_o (res_vld),
        .vrf_starting_addr_rdy_i (res_rdy),
        .vrf_starting_waddr_o    (waddr),
        .vrf_starting_raddr0_o   (raddr0),
        .vrf_starting_raddr1_o   (raddr1),
        .old_preg_o              (old_preg),
        .rel_vld_i               (rel_vld),
        .rel_preg_i              (rel_preg),
        .free_cnt_o              (free_cnt),
        .ovf_err_o               (ovf_err)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [AW-1:0] ws(input int i);  return waddr[i*AW +: AW];  endfunction
    function automatic logic [AW-1:0] r0s(input int i); return raddr0[i*AW +: AW]; endfunction
    function automatic logic [AW-1:0] r1s(input int i); return raddr1[i*AW +: AW]; endfunction
    function automatic logic [PW-1:0] ops(input int i); return old_preg[i*PW +: PW]; endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Present one request, then wait at most max_cyc edges (counting the accept) for vld.
    task automatic issue(input logic [4:0] vd, input logic [4:0] vs1, input logic [4:0] vs2,
                         input logic [1:0] lm, input logic w, input int max_cyc,
                         output int l, output logic g);
        check("rdy_before_issue", instr_rdy, 1'b1);
        instr     = {7'b0, vs2, vs1, 3'b0, vd, 7'b0};
        lmul      = lm;
        we        = w;
        instr_vld = 1'b1;
        tick();
        instr_vld = 1'b0;
        l = 1;
        while (!res_vld && l < max_cyc) begin
            tick();
            l++;
        end
        g = res_vld;
    endtask

    task automatic consume();
        res_rdy = 1'b1;
        tick();
        res_rdy = 1'b0;
        check("vld_after_consume", res_vld, 1'b0);
        check("idle_after_consume", instr_rdy, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        do_reset();
        check("rst_free_cnt", free_cnt, 16);
        check("rst_vld", res_vld, 1'b0);
        check("rst_ovf", ovf_err, 1'b0);
        check("rst_rdy", instr_rdy, 1'b1);
        check("rst_waddr", waddr, '0);
        check("rst_old", old_preg, '0);

        // single register rename
        issue(5'd2, 5'd3, 5'd4, 2'd0, 1'b1, 10, lat, got);
        check("t1_lat", lat, 2);
        check("t1_got", got, 1'b1);
        check("t1_waddr0", ws(0), 512);
        check("t1_waddr1", ws(1), 0);
        check("t1_raddr0_0", r0s(0), 48);
        check("t1_raddr0_1", r0s(1), 64);
        check("t1_raddr1_0", r1s(0), 64);
        check("t1_old0", ops(0), 2);
        check("t1_old1", ops(1), 0);
        check("t1_free_cnt", free_cnt, 15);
        consume();

        // group of 4 wrapping past v31
        do_reset();
        issue(5'd30, 5'd30, 5'd5, 2'd2, 1'b1, 20, lat, got);
        check("t2_lat", lat, 5);
        check("t2_waddr0", ws(0), 512);
        check("t2_waddr1", ws(1), 528);
        check("t2_waddr2", ws(2), 544);
        check("t2_waddr3", ws(3), 560);
        check("t2_waddr4", ws(4), 0);
        check("t2_old0", ops(0), 30);
        check("t2_old1", ops(1), 31);
        check("t2_old2", ops(2), 0);
        check("t2_old3", ops(3), 1);
        check("t2_old4", ops(4), 0);
        check("t2_raddr0_0", r0s(0), 480);
        check("t2_raddr0_2", r0s(2), 0);
        check("t2_raddr0_3", r0s(3), 16);
        check("t2_raddr1_0", r1s(0), 80);
        check("t2_free_cnt", free_cnt, 12);
        consume();

        // read-only request sees the new mappings; hold result for 3 cycles
        issue(5'd0, 5'd30, 5'd0, 2'd2, 1'b0, 10, lat, got);
        check("t3_lat", lat, 1);
        res_rdy = 1'b0;
        for (int c = 0; c < 3; c++) begin
            check("t3_vld_hold", res_vld, 1'b1);
            check("t3_rdy_hold", instr_rdy, 1'b0);
            check("t3_raddr0_0", r0s(0), 512);
            check("t3_raddr0_2", r0s(2), 544);
            check("t3_raddr1_0", r1s(0), 544);
            check("t3_raddr1_2", r1s(2), 32);
            check("t3_waddr", waddr, '0);
            check("t3_old", old_preg, '0);
            tick();
        end
        consume();

        // exhaust the free list, then stall until a release arrives
        do_reset();
        issue(5'd0, 5'd0, 5'd0, 2'd3, 1'b1, 20, lat, got);
        check("t4_lat_a", lat, 9);
        consume();
        issue(5'd8, 5'd0, 5'd0, 2'd3, 1'b1, 20, lat, got);
        check("t4_lat_b", lat, 9);
        consume();
        check("t4_empty", free_cnt, 0);
        issue(5'd16, 5'd0, 5'd0, 2'd0, 1'b1, 5, lat, got);
        check("t4_stall_vld", got, 1'b0);
        check("t4_stall_rdy", instr_rdy, 1'b0);
        check("t4_stall_cnt", free_cnt, 0);
        rel_vld  = 1'b1;
        rel_preg = 6'd5;
        tick();
        rel_vld  = 1'b0;
        check("t4_rel_cnt", free_cnt, 1);
        check("t4_rel_vld", res_vld, 1'b0);
        tick();
        check("t4_pop_vld", res_vld, 1'b1);
        check("t4_pop_waddr0", ws(0), 80);
        check("t4_pop_old0", ops(0), 16);
        check("t4_pop_cnt", free_cnt, 0);
        check("t4_ovf", ovf_err, 1'b0);
        consume();

        // release into a full list while a pop happens: accepted, no overflow
        do_reset();
        issue(5'd3, 5'd0, 5'd0, 2'd0, 1'b1, 1, lat, got);
        check("t5_alloc", got, 1'b0);
        rel_vld  = 1'b1;
        rel_preg = 6'd40;
        tick();
        rel_vld  = 1'b0;
        check("t5_vld", res_vld, 1'b1);
        check("t5_cnt", free_cnt, 16);
        check("t5_ovf", ovf_err, 1'b0);
        check("t5_waddr0", ws(0), 512);
        consume();

        // release into a full list with no pop: dropped, sticky overflow
        do_reset();
        rel_vld  = 1'b1;
        rel_preg = 6'd7;
        tick();
        rel_vld  = 1'b0;
        check("t6_cnt", free_cnt, 16);
        check("t6_ovf", ovf_err, 1'b1);
        tick();
        tick();
        check("t6_ovf_sticky", ovf_err, 1'b1);
        do_reset();
        check("t6_ovf_cleared", ovf_err, 1'b0);

        // reset in the middle of an 8-register allocation
        issue(5'd0, 5'd0, 5'd0, 2'd3, 1'b1, 3, lat, got);
        check("t7_mid_alloc", got, 1'b0);
        check("t7_mid_cnt", free_cnt, 14);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t7_cnt", free_cnt, 16);
        check("t7_vld", res_vld, 1'b0);
        check("t7_rdy", instr_rdy, 1'b1);
        check("t7_waddr", waddr, '0);
        issue(5'd0, 5'd0, 5'd4, 2'd0, 1'b0, 10, lat, got);
        check("t7_read_lat", lat, 1);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("t7_raddr0_%0d", i), r0s(i), 16 * i);
            check($sformatf("t7_raddr1_%0d", i), r1s(i), 16 * (4 + i));
        end
        consume();
        issue(5'd3, 5'd0, 5'd0, 2'd0, 1'b1, 10, lat, got);
        check("t7_realloc_waddr0", ws(0), 512);
        check("t7_realloc_old0", ops(0), 3);
        consume();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
